// File: rtl/sys_fifo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sys_fifo_ctrl_pkg
//  Purpose  : Width defaults and the controller FSM state encoding shared by
//             sdram_fifo_ctrl and its sub-blocks.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package sys_fifo_ctrl_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int ADDR_W_DEF     = 24;
  localparam int LEN_W_DEF      = 10;
  localparam int FIFO_DEPTH_DEF = 1024;
  localparam int REGION_LEN_DEF = 1024;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_REQ   = 3'd1,
    ST_WR_BURST = 3'd2,
    ST_RD_REQ   = 3'd3,
    ST_RD_BURST = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock show-ahead FIFO. data_o always presents the head
//             word; pop_i only advances the read pointer.
//  Ports    : clk_i, rst_ni (async active-low), clr_i (sync clear),
//             push_i/data_i (write side), pop_i/data_o (read side),
//             count_o (words stored, 0..DEPTH)
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        data_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [AW:0]       count_q;
  logic              do_push, do_pop;

  // Push into a full FIFO and pop from an empty one are silently dropped.
  assign do_push = push_i & (count_q != (AW+1)'(DEPTH));
  assign do_pop  = pop_i  & (count_q != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (clr_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
      else if (!do_push && do_pop) count_q <= count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i) mem_q[wptr_q] <= data_i;
  end

  assign data_o  = mem_q[rptr_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/sdram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_fifo_ctrl
//  Purpose  : Buffers user write/read streams for an SDRAM command controller.
//             A write FIFO feeds burst writes, a read FIFO is refilled by
//             burst reads. One burst outstanding at a time, writes first.
//  Ports    : sys_clk/sys_rst_n; user write side wr_fifo_*, wr_burst_len,
//             wr_b_addr, wr_rst; user read side rd_fifo_*, rd_burst_len,
//             rd_b_addr, rd_rst; init_end; SDRAM side sdram_wr_*/sdram_rd_*,
//             sdram_data_in/out, sdram_data_valid.
//  Options  : SYS_FIFO_CTRL_RD_GATE_EN - issue a read burst only while more
//             write bursts than read bursts have completed.
//  Revision : 1.0 - initial release
// ============================================================================
module sdram_fifo_ctrl
  import sys_fifo_ctrl_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int LEN_W      = LEN_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int REGION_LEN = REGION_LEN_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              wr_fifo_wr_req,
  input  logic [DATA_W-1:0] wr_fifo_wr_data,
  input  logic [LEN_W-1:0]  wr_burst_len,
  input  logic [ADDR_W-1:0] wr_b_addr,
  input  logic              wr_rst,
  output logic              wr_fifo_rdy,
  input  logic              rd_fifo_rd_req,
  output logic [DATA_W-1:0] rd_fifo_rd_data,
  input  logic [LEN_W-1:0]  rd_burst_len,
  input  logic [ADDR_W-1:0] rd_b_addr,
  input  logic              rd_rst,
  output logic              rd_fifo_rdy,
  input  logic              init_end,
  input  logic              sdram_wr_ack,
  output logic              sdram_wr_req,
  output logic [ADDR_W-1:0] sdram_wr_addr,
  output logic [LEN_W-1:0]  sdram_wr_burst_len,
  output logic [DATA_W-1:0] sdram_data_in,
  input  logic              sdram_rd_ack,
  output logic              sdram_rd_req,
  output logic [ADDR_W-1:0] sdram_rd_addr,
  output logic [LEN_W-1:0]  sdram_rd_burst_len,
  input  logic              sdram_data_valid,
  input  logic [DATA_W-1:0] sdram_data_out
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  wr_len_q, rd_len_q;
  logic [ADDR_W-1:0] wr_off_q, wr_off_d, rd_off_q, rd_off_d;
  logic              wr_abort_q, rd_abort_q;
  logic [DATA_W-1:0] rd_data_q;

  logic [CNT_W-1:0]  wr_cnt, rd_cnt;
  logic [DATA_W-1:0] rd_head;
  logic              wr_push, wr_pop, rd_push, rd_pop;
  logic              wr_active, rd_active, wr_exit, rd_exit;
  logic              wr_thresh, rd_space_ok, rd_gate;
  logic [ADDR_W-1:0] wr_sum, rd_sum;

  // ---------------------------------------------------------------- FIFOs
  sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
    .clk_i(sys_clk), .rst_ni(sys_rst_n), .clr_i(!wr_rst),
    .push_i(wr_push), .data_i(wr_fifo_wr_data),
    .pop_i(wr_pop), .data_o(sdram_data_in), .count_o(wr_cnt)
  );

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
    .clk_i(sys_clk), .rst_ni(sys_rst_n), .clr_i(!rd_rst),
    .push_i(rd_push), .data_i(sdram_data_out),
    .pop_i(rd_pop), .data_o(rd_head), .count_o(rd_cnt)
  );

  assign wr_fifo_rdy = init_end & (wr_cnt != CNT_W'(FIFO_DEPTH));
  assign wr_push     = wr_fifo_wr_req & wr_fifo_rdy;
  assign rd_fifo_rdy = (rd_cnt != '0);
  assign rd_pop      = rd_fifo_rd_req & rd_fifo_rdy;

  assign wr_active = (state_q == ST_WR_REQ) || (state_q == ST_WR_BURST);
  assign rd_active = (state_q == ST_RD_REQ) || (state_q == ST_RD_BURST);
  assign wr_exit   = (state_q == ST_WR_BURST) && !sdram_wr_ack;
  assign rd_exit   = (state_q == ST_RD_BURST) && !sdram_rd_ack;

  assign wr_thresh   = 32'(wr_cnt) >= 32'(wr_burst_len);
  assign rd_space_ok = (32'(FIFO_DEPTH) - 32'(rd_cnt)) >= 32'(rd_burst_len);

  // ----------------------------------------------------- optional read gate
`ifdef SYS_FIFO_CTRL_RD_GATE_EN
  logic [7:0] bal_q;

  // Completed write bursts minus completed read bursts; both exits can never
  // coincide because only one burst is in flight.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)   bal_q <= '0;
    else if (wr_exit) bal_q <= bal_q + 8'd1;
    else if (rd_exit) bal_q <= bal_q - 8'd1;
  end

  assign rd_gate = (bal_q != 8'd0);
`else
  assign rd_gate = 1'b1;
`endif

  // ------------------------------------------------------------ FSM state
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (init_end) begin
          if (wr_thresh && wr_rst)                  state_d = ST_WR_REQ;
          else if (rd_space_ok && rd_rst && rd_gate) state_d = ST_RD_REQ;
        end
      end
      ST_WR_REQ:   if (sdram_wr_ack)  state_d = ST_WR_BURST;
      ST_WR_BURST: if (!sdram_wr_ack) state_d = ST_IDLE;
      ST_RD_REQ:   if (sdram_rd_ack)  state_d = ST_RD_BURST;
      ST_RD_BURST: if (!sdram_rd_ack) state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
  end

  // The first ack arrives while still in the REQ state and already moves a
  // data word, so data transfer is qualified by the whole active window.
  // After a mid-burst clear the handshake runs on but moves no data.
  always_comb begin
    sdram_wr_req = (state_q == ST_WR_REQ) && !sdram_wr_ack;
    sdram_rd_req = (state_q == ST_RD_REQ) && !sdram_rd_ack;
    wr_pop       = wr_active && sdram_wr_ack && wr_rst && !wr_abort_q;
    rd_push      = rd_active && sdram_data_valid && rd_rst && !rd_abort_q;
  end

  // ------------------------------------------------------ offsets/lengths
  assign wr_sum = wr_off_q + ADDR_W'(wr_len_q);
  assign rd_sum = rd_off_q + ADDR_W'(rd_len_q);

  // Wrap early: if the following burst would not fit in the region, the
  // next burst restarts at the region base.
  always_comb begin
    wr_off_d = wr_off_q;
    if (!wr_rst) wr_off_d = '0;
    else if (wr_exit) begin
      if (wr_abort_q || (32'(wr_sum) + 32'(wr_len_q) > 32'(REGION_LEN))) wr_off_d = '0;
      else wr_off_d = wr_sum;
    end
  end

  always_comb begin
    rd_off_d = rd_off_q;
    if (!rd_rst) rd_off_d = '0;
    else if (rd_exit) begin
      if (rd_abort_q || (32'(rd_sum) + 32'(rd_len_q) > 32'(REGION_LEN))) rd_off_d = '0;
      else rd_off_d = rd_sum;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_off_q   <= '0;
      rd_off_q   <= '0;
      wr_len_q   <= '0;
      rd_len_q   <= '0;
      wr_abort_q <= 1'b0;
      rd_abort_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_off_q <= wr_off_d;
      rd_off_q <= rd_off_d;
      if (state_q == ST_IDLE && state_d == ST_WR_REQ) wr_len_q <= wr_burst_len;
      if (state_q == ST_IDLE && state_d == ST_RD_REQ) rd_len_q <= rd_burst_len;
      if (!wr_active)  wr_abort_q <= 1'b0;
      else if (!wr_rst) wr_abort_q <= 1'b1;
      if (!rd_active)  rd_abort_q <= 1'b0;
      else if (!rd_rst) rd_abort_q <= 1'b1;
      if (rd_pop) rd_data_q <= rd_head;
    end
  end

  assign sdram_wr_addr      = wr_b_addr + wr_off_q;
  assign sdram_rd_addr      = rd_b_addr + rd_off_q;
  assign sdram_wr_burst_len = wr_len_q;
  assign sdram_rd_burst_len = rd_len_q;
  assign rd_fifo_rd_data    = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdram_fifo_ctrl
//  Purpose  : Directed self-checking bench for sdram_fifo_ctrl (REGION_LEN 16)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_fifo_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        wr_fifo_wr_req;
  logic [15:0] wr_fifo_wr_data;
  logic [9:0]  wr_burst_len;
  logic [23:0] wr_b_addr;
  logic        wr_rst;
  logic        wr_fifo_rdy;
  logic        rd_fifo_rd_req;
  logic [15:0] rd_fifo_rd_data;
  logic [9:0]  rd_burst_len;
  logic [23:0] rd_b_addr;
  logic        rd_rst;
  logic        rd_fifo_rdy;
  logic        init_end;
  logic        sdram_wr_ack;
  logic        sdram_wr_req;
  logic [23:0] sdram_wr_addr;
  logic [9:0]  sdram_wr_burst_len;
  logic [15:0] sdram_data_in;
  logic        sdram_rd_ack;
  logic        sdram_rd_req;
  logic [23:0] sdram_rd_addr;
  logic [9:0]  sdram_rd_burst_len;
  logic        sdram_data_valid;
  logic [15:0] sdram_data_out;

  int checks   = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;

  sdram_fifo_ctrl #(.REGION_LEN(16)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .wr_fifo_wr_req(wr_fifo_wr_req), .wr_fifo_wr_data(wr_fifo_wr_data),
    .wr_burst_len(wr_burst_len), .wr_b_addr(wr_b_addr), .wr_rst(wr_rst),
    .wr_fifo_rdy(wr_fifo_rdy),
    .rd_fifo_rd_req(rd_fifo_rd_req), .rd_fifo_rd_data(rd_fifo_rd_data),
    .rd_burst_len(rd_burst_len), .rd_b_addr(rd_b_addr), .rd_rst(rd_rst),
    .rd_fifo_rdy(rd_fifo_rdy), .init_end(init_end),
    .sdram_wr_ack(sdram_wr_ack), .sdram_wr_req(sdram_wr_req),
    .sdram_wr_addr(sdram_wr_addr), .sdram_wr_burst_len(sdram_wr_burst_len),
    .sdram_data_in(sdram_data_in),
    .sdram_rd_ack(sdram_rd_ack), .sdram_rd_req(sdram_rd_req),
    .sdram_rd_addr(sdram_rd_addr), .sdram_rd_burst_len(sdram_rd_burst_len),
    .sdram_data_valid(sdram_data_valid), .sdram_data_out(sdram_data_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push8(input logic [15:0] base);
    for (int i = 0; i < 8; i++) begin
      wr_fifo_wr_req  = 1'b1;
      wr_fifo_wr_data = base + 16'(i);
      tick();
    end
    wr_fifo_wr_req = 1'b0;
  endtask

  // 8 acks starting in WR_REQ, then one ack-low cycle that exits the burst.
  task automatic wr_burst(input logic [15:0] base);
    for (int i = 0; i < 8; i++) begin
      sdram_wr_ack = 1'b1;
      #1;
      chk("wr_data", sdram_data_in, base + 16'(i));
      if (i == 0) chk("wr_req_drop", sdram_wr_req, 0);
      tick();
    end
    sdram_wr_ack = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not terminate");
  end

  initial begin
    sys_rst_n = 1'b0; wr_fifo_wr_req = 1'b0; wr_fifo_wr_data = '0;
    wr_burst_len = 10'd8; wr_b_addr = 24'h100; wr_rst = 1'b1;
    rd_fifo_rd_req = 1'b0; rd_burst_len = 10'd8; rd_b_addr = 24'h100;
    rd_rst = 1'b0; init_end = 1'b0; sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0;
    sdram_data_valid = 1'b0; sdram_data_out = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_wr_req", sdram_wr_req, 0);
    chk("rst_rd_req", sdram_rd_req, 0);
    chk("rst_wr_addr", sdram_wr_addr, 24'h100);
    chk("rst_rd_addr", sdram_rd_addr, 24'h100);
    chk("rst_wr_len", sdram_wr_burst_len, 0);
    chk("rst_rd_len", sdram_rd_burst_len, 0);
    chk("rst_rd_data", rd_fifo_rd_data, 0);
    chk("rst_wr_rdy", wr_fifo_rdy, 0);
    chk("rst_rd_rdy", rd_fifo_rdy, 0);
    sys_rst_n = 1'b1;
    tick();

    // Pushes before init_end are refused; nothing is requested
    push8(16'h5500);
    #1;
    chk("noinit_wr_req", sdram_wr_req, 0);
    chk("noinit_rd_req", sdram_rd_req, 0);
    chk("noinit_wr_rdy", wr_fifo_rdy, 0);

    // First write burst A0..A7 at 0x100
    init_end = 1'b1;
    #1;
    chk("init_wr_rdy", wr_fifo_rdy, 1);
    push8(16'hA0A0);
    #1;
    chk("wr_req_latency", sdram_wr_req, 0);
    tick();
    chk("b1_wr_req", sdram_wr_req, 1);
    chk("b1_wr_addr", sdram_wr_addr, 24'h100);
    chk("b1_wr_len", sdram_wr_burst_len, 8);
    wr_burst(16'hA0A0);
    chk("b1_exit_req", sdram_wr_req, 0);
    chk("b1_next_addr", sdram_wr_addr, 24'h108);

    // Second write burst at 0x108; region of 16 wraps afterwards
    push8(16'hC0C0);
    tick();
    chk("b2_wr_req", sdram_wr_req, 1);
    chk("b2_wr_addr", sdram_wr_addr, 24'h108);
    wr_burst(16'hC0C0);
    chk("b2_wrap_addr", sdram_wr_addr, 24'h100);

    // Third write burst: write threshold and read space met together
    push8(16'hD0D0);
    rd_rst = 1'b1;
    tick();
    chk("prio_wr_req", sdram_wr_req, 1);
    chk("prio_rd_req", sdram_rd_req, 0);
    chk("b3_wr_addr", sdram_wr_addr, 24'h100);
    wr_burst(16'hD0D0);
    chk("prio_rd_idle", sdram_rd_req, 0);
    chk("b3_next_addr", sdram_wr_addr, 24'h108);
    tick();
    chk("rd_req", sdram_rd_req, 1);
    chk("rd_addr", sdram_rd_addr, 24'h100);
    chk("rd_len", sdram_rd_burst_len, 8);

    // Read burst B0..B7
    for (int i = 0; i < 8; i++) begin
      sdram_rd_ack = 1'b1; sdram_data_valid = 1'b1;
      sdram_data_out = 16'hB0B0 + 16'(i);
      #1;
      if (i == 0) chk("rd_req_drop", sdram_rd_req, 0);
      tick();
    end
    sdram_rd_ack = 1'b0; sdram_data_valid = 1'b0;
    tick();
    chk("rd_rdy", rd_fifo_rdy, 1);
    chk("rd_next_addr", sdram_rd_addr, 24'h108);
    tick();
    chk("rd_req2", sdram_rd_req, 1);

    // User reads, one cycle latency, then pop while empty holds data
    for (int i = 0; i < 8; i++) begin
      rd_fifo_rd_req = 1'b1;
      tick();
      chk("rd_data", rd_fifo_rd_data, 16'hB0B0 + 16'(i));
    end
    chk("rd_empty", rd_fifo_rdy, 0);
    tick();
    chk("rd_hold", rd_fifo_rd_data, 16'hB0B7);
    rd_fifo_rd_req = 1'b0;

    // Read clear mid-handshake: data during the rest of the burst is dropped
    rd_rst = 1'b0; sdram_rd_ack = 1'b1; sdram_data_valid = 1'b1;
    sdram_data_out = 16'hEEEE;
    tick();
    rd_rst = 1'b1; sdram_data_out = 16'hEEEF;
    tick();
    sdram_rd_ack = 1'b0; sdram_data_valid = 1'b0;
    tick();
    chk("rdclr_rdy", rd_fifo_rdy, 0);
    chk("rdclr_addr", sdram_rd_addr, 24'h100);
    rd_rst = 1'b0;
    tick();

    // Write clear in IDLE zeroes the offset
    chk("wrclr_pre_addr", sdram_wr_addr, 24'h108);
    wr_rst = 1'b0;
    tick();
    wr_rst = 1'b1;
    #1;
    chk("wrclr_idle_addr", sdram_wr_addr, 24'h100);

    // Write clear during WR_BURST; user pushes F0..F4 later in that burst
    push8(16'hE0E0);
    tick();
    chk("b4_wr_req", sdram_wr_req, 1);
    for (int i = 0; i < 8; i++) begin
      sdram_wr_ack = 1'b1;
      wr_rst = (i == 2) ? 1'b0 : 1'b1;
      wr_fifo_wr_req  = (i >= 3);
      wr_fifo_wr_data = 16'hF0F0 + 16'(i - 3);
      #1;
      if (i < 2) chk("b4_wr_data", sdram_data_in, 16'hE0E0 + 16'(i));
      tick();
    end
    sdram_wr_ack = 1'b0; wr_rst = 1'b1; wr_fifo_wr_req = 1'b0;
    tick();
    chk("wrclr_burst_addr", sdram_wr_addr, 24'h100);
    chk("wrclr_burst_req", sdram_wr_req, 0);
    for (int i = 5; i < 8; i++) begin
      wr_fifo_wr_req  = 1'b1;
      wr_fifo_wr_data = 16'hF0F0 + 16'(i);
      tick();
    end
    wr_fifo_wr_req = 1'b0;
    tick();
    chk("b5_wr_req", sdram_wr_req, 1);
    chk("b5_wr_addr", sdram_wr_addr, 24'h100);
    sdram_wr_ack = 1'b1;
    #1;
    chk("b5_first_data", sdram_data_in, 16'hF0F0);
    tick();
    sdram_wr_ack = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
